// File: rtl/jk_prog_divider_if.sv
// Handshake/bus bundle for the programmable divider.
// master: ratio/enable source; slave: the divider.
interface jk_prog_divider_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_ratio;
    logic             div_load;
    logic             mod_plus;
    logic             div_ack;
    logic             tc_pulse;
    logic             clk_div_out;
    logic [WIDTH:0]   count;

    modport master (
        output en,
        output div_ratio,
        output div_load,
        output mod_plus,
        input  div_ack,
        input  tc_pulse,
        input  clk_div_out,
        input  count
    );

    modport slave (
        input  en,
        input  div_ratio,
        input  div_load,
        input  mod_plus,
        output div_ack,
        output tc_pulse,
        output clk_div_out,
        output count
    );
endinterface

// File: rtl/jk_prog_divider.sv
// Programmable N / N+1 divider for the PLL feedback path.
// Ports: clk, rst (sync, active-high), bus (slave: en, div_ratio,
// div_load, mod_plus in; div_ack, tc_pulse, clk_div_out, count out).
module jk_prog_divider #(
    parameter int WIDTH   = 8,
    parameter int RST_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    jk_prog_divider_if.slave    bus
);
    localparam int CW = WIDTH + 1;

    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_vld_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    neff_q;
    logic             clk_q;
    logic             ack_q;

    logic             reload;
    logic [WIDTH-1:0] sel_ratio;
    logic [CW-1:0]    neff_new;
    logic [CW-1:0]    neff_d;
    logic [CW-1:0]    cnt_d;
    logic             clk_d;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        reload    = bus.en && (cnt_q == '0);
        sel_ratio = pend_vld_q ? pend_q : active_q;
        // One extra bit keeps N + 1 = 2^WIDTH representable.
        neff_new  = {1'b0, sel_ratio} + CW'(bus.mod_plus);
        neff_d    = reload ? neff_new : neff_q;
        cnt_d     = reload ? (neff_new - CW'(1))
                           : (cnt_q - CW'(1));
        // High for the upper ceil(N/2) counts of the period.
        clk_d     = (cnt_d >= (neff_d >> 1));
        load_val  = (bus.div_ratio < WIDTH'(2))
                  ? WIDTH'(2) : bus.div_ratio;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= WIDTH'(RST_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= CW'(RST_DIV - 1);
            neff_q     <= CW'(RST_DIV);
            clk_q      <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= reload && pend_vld_q;
            if (bus.en) begin
                cnt_q  <= cnt_d;
                neff_q <= neff_d;
                clk_q  <= clk_d;
            end
            if (reload && pend_vld_q)
                active_q <= pend_q;
            // A load coincident with a reload refills pending
            // for the following boundary.
            if (bus.div_load) begin
                pend_q     <= load_val;
                pend_vld_q <= 1'b1;
            end else if (reload) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign bus.tc_pulse    = bus.en && (cnt_q == '0);
    assign bus.div_ack     = ack_q;
    assign bus.clk_div_out = clk_q;
    assign bus.count       = cnt_q;
endmodule

// File: tb/tb_jk_prog_divider.sv
// Self-checking bench for jk_prog_divider.
// Table vectors, directed corner sequences and random traffic.
module tb_jk_prog_divider;
    localparam int W  = 8;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_prog_divider_if #(.WIDTH(W)) bus ();

    jk_prog_divider #(.WIDTH(W), .RST_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: position within period and period length.
    int m_active, m_pend, m_neff, m_pos;
    bit m_pvld, m_ack, m_en;

    typedef struct {
        bit en;
        bit load;
        int ratio;
        bit mod;
        int cnt;
        bit tc;
        bit cd;
        bit ack;
    } vec_t;

    vec_t tbl[13];

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void model_step(bit r, bit e, bit l,
                                       int ratio, bit m);
        if (r) begin
            m_active = RD; m_pend = 0; m_pvld = 0;
            m_neff = RD; m_pos = 0; m_ack = 0;
        end else begin
            m_ack = 0;
            if (e) begin
                if (m_pos == m_neff - 1) begin
                    if (m_pvld) begin
                        m_active = m_pend;
                        m_pvld = 0;
                        m_ack = 1;
                    end
                    m_neff = m_active + int'(m);
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (l) begin
                m_pend = (ratio < 2) ? 2 : ratio;
                m_pvld = 1;
            end
        end
        m_en = e;
    endfunction

    function automatic void check_model();
        chk("count", int'(bus.count), m_neff - 1 - m_pos);
        chk("tc", int'(bus.tc_pulse),
            int'(m_en && m_pos == m_neff - 1));
        chk("clk_div", int'(bus.clk_div_out),
            int'(m_pos < (m_neff + 1) / 2));
        chk("ack", int'(bus.div_ack), int'(m_ack));
    endfunction

    task automatic cycle(bit e, bit l, int r, bit m);
        bus.en = e;
        bus.div_load = l;
        bus.div_ratio = W'(r);
        bus.mod_plus = m;
        @(posedge clk);
        model_step(rst, e, l, r, m);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // Runs en=1 cycles until tc is seen; returns cycle count.
    task automatic run_to_tc(bit m, output int n, output int acks);
        n = 0;
        acks = 0;
        do begin
            cycle(1, 0, 0, m);
            n++;
            acks += int'(bus.div_ack);
        end while (!bus.tc_pulse && n < 600);
        if (!bus.tc_pulse) chk("tc_timeout", n, -1);
    endtask

    function automatic vec_t mk(bit e, bit l, int r, int c,
                                bit t, bit d, bit a);
        vec_t v;
        v.en = e; v.load = l; v.ratio = r; v.mod = 0;
        v.cnt = c; v.tc = t; v.cd = d; v.ack = a;
        return v;
    endfunction

    initial begin
        int n, acks, tot, tcs;
        bus.en = 0; bus.div_load = 0;
        bus.div_ratio = '0; bus.mod_plus = 0;
        @(negedge clk);

        tbl[0]  = mk(1, 0, 0, 2, 0, 1, 0);
        tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(1, 0, 0, 3, 0, 1, 0);
        tbl[4]  = mk(1, 1, 5, 2, 0, 1, 0);
        tbl[5]  = mk(1, 0, 0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 0, 0, 4, 0, 1, 1);
        tbl[8]  = mk(1, 0, 0, 3, 0, 1, 0);
        tbl[9]  = mk(1, 0, 0, 2, 0, 1, 0);
        tbl[10] = mk(1, 0, 0, 1, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(1, 0, 0, 4, 0, 1, 0);

        do_reset();
        chk("rst_count", int'(bus.count), RD - 1);
        chk("rst_clk", int'(bus.clk_div_out), 1);
        chk("rst_ack", int'(bus.div_ack), 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].en, tbl[i].load, tbl[i].ratio, tbl[i].mod);
            chk($sformatf("tbl%0d_cnt", i), int'(bus.count), tbl[i].cnt);
            chk($sformatf("tbl%0d_tc", i), int'(bus.tc_pulse),
                int'(tbl[i].tc));
            chk($sformatf("tbl%0d_cd", i), int'(bus.clk_div_out),
                int'(tbl[i].cd));
            chk($sformatf("tbl%0d_ack", i), int'(bus.div_ack),
                int'(tbl[i].ack));
        end

        // Dual modulus: ratio 8, +1 on alternate periods.
        do_reset();
        cycle(1, 1, 8, 0);
        run_to_tc(0, n, acks);
        tot = 0;
        tcs = 0;
        for (int p = 0; p < 100; p++) begin
            run_to_tc(bit'(p % 2), n, acks);
            chk($sformatf("nn1_p%0d", p), n, 8 + (p % 2));
            tot += n;
            tcs++;
        end
        chk("nn1_total", tot, 850);
        chk("nn1_tcs", tcs, 100);

        // Clamp of ratio 1, then 255 with +1.
        do_reset();
        cycle(1, 1, 1, 0);
        run_to_tc(0, n, acks);
        cycle(1, 0, 0, 0);
        chk("clamp_cnt", int'(bus.count), 1);
        chk("clamp_ack", int'(bus.div_ack), 1);
        cycle(1, 1, 255, 0);
        chk("clamp_tc", int'(bus.tc_pulse), 1);
        cycle(1, 0, 0, 1);
        chk("n256_cnt", int'(bus.count), 255);
        chk("n256_cd", int'(bus.clk_div_out), 1);
        for (int i = 0; i < 127; i++) cycle(1, 0, 0, 0);
        chk("n256_hi_end", int'(bus.clk_div_out), 1);
        cycle(1, 0, 0, 0);
        chk("n256_half", int'(bus.count), 127);
        chk("n256_lo", int'(bus.clk_div_out), 0);

        // Back-to-back loads, then a load on the tc cycle.
        do_reset();
        cycle(1, 1, 6, 0);
        cycle(1, 1, 7, 0);
        cycle(1, 0, 0, 0);
        chk("b2b_tc", int'(bus.tc_pulse), 1);
        cycle(1, 1, 3, 0);
        chk("b2b_cnt", int'(bus.count), 6);
        chk("b2b_ack", int'(bus.div_ack), 1);
        run_to_tc(0, n, acks);
        chk("b2b_len", n, 6);
        chk("b2b_acks", acks, 0);
        cycle(1, 0, 0, 0);
        chk("coin_cnt", int'(bus.count), 2);
        chk("coin_ack", int'(bus.div_ack), 1);

        // Freeze with en=0 at count 2, then reset with pending.
        do_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            chk("frz_cnt", int'(bus.count), 2);
            chk("frz_tc", int'(bus.tc_pulse), 0);
        end
        cycle(1, 0, 0, 0);
        chk("res_cnt1", int'(bus.count), 1);
        cycle(0, 1, 9, 0);
        cycle(1, 0, 0, 0);
        chk("res_cnt0", int'(bus.count), 0);
        do_reset();
        chk("rst2_cnt", int'(bus.count), RD - 1);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, 0);
            acks += int'(bus.div_ack);
        end
        chk("rst2_acks", acks, 0);
        chk("rst2_cnt_after", int'(bus.count), RD - 1);

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            bit e, l, m;
            int r;
            e = ($urandom_range(0, 7) != 0);
            l = ($urandom_range(0, 9) == 0);
            m = 1'($urandom);
            r = ($urandom_range(0, 19) == 0) ? 255
              : int'($urandom_range(0, 12));
            cycle(e, l, r, m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_prog_divider.md
Name: jk_prog_divider

Overview:
- Parametrised programmable synchronous divider for the PLL feedback path; the successor of the single-bit JK/DFF toggle stages.
- Divides `clk` by a run-time ratio N, with an optional per-period +1 (N/N+1 dual-modulus) for the fractional-N sigma-delta controller.
- Outputs: a one-cycle terminal-count pulse, a near-50% divided clock and the live count.
- Ratio changes are double-buffered and take effect only at a period boundary, with an acknowledge.

Parameters:
- WIDTH, 8, bit width of the ratio input; the internal counter is WIDTH+1 bits.
- RST_DIV, 4, ratio active after reset; legal range 2..2^WIDTH-1.

Ports:
- clk  in  1  divider input clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; 0 freezes counter and outputs
- div_ratio  in  WIDTH  requested ratio N, sampled when div_load=1
- div_load  in  1  one-cycle strobe: capture div_ratio into the pending register
- mod_plus  in  1  sampled at each reload; 1 makes the next period N+1 cycles
- div_ack  out  1  one-cycle pulse: pending ratio has become active
- tc_pulse  out  1  one-cycle pulse on the last cycle of each period (count==0 and en)
- clk_div_out  out  1  registered divided clock
- count  out  WIDTH+1  current down-counter value

Behaviour:
- Reset (rst=1 at an edge, overrides everything):
  - active ratio = RST_DIV; pending register cleared.
  - count = RST_DIV-1; clk_div_out = 1.
  - tc_pulse = 0; div_ack = 0.
- Ratio sanitising: a div_ratio value of 0 or 1 is clamped to 2 at capture. No other ratio checks.
- Counting, when en=1:
  - count != 0: count decrements by 1.
  - count == 0: reload. count <= Neff-1, where Neff = R + mod_plus and R is the ratio chosen below. WIDTH+1-bit arithmetic, so Neff = 2^WIDTH is legal with no overflow.
- Ratio chosen at reload:
  - If pending is valid, R = pending; pending becomes active; pending_valid clears; div_ack=1 in the cycle after the reload edge.
  - Otherwise R = the active ratio.
- tc_pulse: combinational from registered state, `tc_pulse = en & (count==0)`. It marks the last cycle of each period. Period = Neff cycles exactly.
- clk_div_out:
  - Registered. Next value = (count_next >= half), where half = Neff_cur >> 1 and Neff_cur is the Neff of the period count_next belongs to.
  - Result: high for ceil(N/2) cycles, then low for floor(N/2) cycles. Period-aligned with count.
- Load handshake:
  - div_load=1 (en ignored) captures the clamped div_ratio into pending and sets pending_valid.
  - A second load before activation overwrites pending: last value wins, and only one div_ack is produced.
  - A load in the same cycle as a reload does not affect that reload; it applies at the next reload.
- en=0:
  - count, clk_div_out and active ratio hold; tc_pulse=0; div_ack=0.
  - Loads are still captured.
  - Resuming en=1 continues from the held count with no lost or extra cycle.
- Reset mid-period: abandons the period; a pending ratio is discarded without div_ack.
- Single clock domain; no combinational path from inputs to outputs except en→tc_pulse.

Test Plan:
- rst for 2 cycles, en=1, no loads → count 3,2,1,0,3…; tc_pulse every 4th cycle on count==0; clk_div_out 1,1,0,0 repeating.
- div_ratio=5, div_load pulsed mid-period → current period completes at 4 cycles; div_ack one cycle after that reload; then period 5; clk_div_out high 3 and low 2.
- Ratio 8 active, mod_plus=1 sampled at alternate reloads → periods alternate 9,8,9,8; mean ratio 8.5 over 100 periods; tc_pulse count matches.
- div_ratio=1 loaded, then separately div_ratio=255 with mod_plus=1 → first becomes period 2; second gives Neff=256, count reloads 255 with no wrap, half=128.
- Loads of 6 then 7 in consecutive cycles, then a load coinciding with tc → ratio 7 activates with a single div_ack; the coincident load applies only at the following reload.
- en=0 for 3 cycles with count=2 → outputs frozen, tc_pulse=0; resume gives count 1,0. Then rst asserted with a pending load → count=RST_DIV-1 and no div_ack.
